// File: rtl/vending_machine_if.sv
// Coin-acceptor / keypad / dispenser signal bundle for vending_machine.
// The master drives coins and product selection. The slave (the controller) drives the dispense pulse and change.
interface vending_machine_if;
  logic [2:0] in;
  logic [2:0] product_select;
  logic       out;
  logic [2:0] change;

  modport master (
    output in,
    output product_select,
    input  out,
    input  change
  );

  modport slave (
    input  in,
    input  product_select,
    output out,
    output change
  );
endinterface

// File: rtl/vending_machine.sv
// Coin-operated vending controller: accumulates credit, vends with a one-cycle pulse and returns change.
// Optional feature VM_SELECT_LOCK_EN latches product_select on the first coin of a purchase.
module vending_machine #(
  parameter int PRICE_0 = 5,
  parameter int PRICE_1 = 6,
  parameter int PRICE_2 = 8,
  parameter int PRICE_3 = 10,
  parameter int PRICE_4 = 12,
  parameter int PRICE_5 = 15,
  parameter int PRICE_6 = 3,
  parameter int PRICE_7 = 20
) (
  input  logic             clk,
  input  logic             rst,
  vending_machine_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    VEND
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] credit_q, credit_d;
  logic       out_q, out_d;
  logic [2:0] change_q, change_d;

  logic [2:0] coin_val;
  logic [2:0] eff_sel;
  logic [4:0] price;
  logic [5:0] sum;

`ifdef VM_SELECT_LOCK_EN
  logic [2:0] sel_q, sel_d;

  // The first coin uses the live selection; after that the latched value holds the price.
  assign eff_sel = (state_q == IDLE) ? bus.product_select : sel_q;
`else
  assign eff_sel = bus.product_select;
`endif

  always_comb begin
    coin_val = 3'd0;
    case (bus.in)
      3'b001:  coin_val = 3'd1;
      3'b010:  coin_val = 3'd2;
      3'b011:  coin_val = 3'd5;
      default: coin_val = 3'd0;
    endcase
  end

  always_comb begin
    price = 5'(PRICE_0);
    case (eff_sel)
      3'd0:    price = 5'(PRICE_0);
      3'd1:    price = 5'(PRICE_1);
      3'd2:    price = 5'(PRICE_2);
      3'd3:    price = 5'(PRICE_3);
      3'd4:    price = 5'(PRICE_4);
      3'd5:    price = 5'(PRICE_5);
      3'd6:    price = 5'(PRICE_6);
      default: price = 5'(PRICE_7);
    endcase
  end

  // Credit is zero in IDLE, so one adder serves both the first coin and later coins.
  assign sum = {1'b0, credit_q} + {3'b000, coin_val};

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    out_d    = 1'b0;
    change_d = 3'd0;
`ifdef VM_SELECT_LOCK_EN
    sel_d    = sel_q;
`endif
    case (state_q)
      IDLE, COLLECT: begin
        if (coin_val != 3'd0) begin
`ifdef VM_SELECT_LOCK_EN
          if (state_q == IDLE) begin
            sel_d = bus.product_select;
          end
`endif
          if (sum >= {1'b0, price}) begin
            out_d    = 1'b1;
            change_d = sum[2:0] - price[2:0];
            credit_d = 5'd0;
            state_d  = VEND;
          end else begin
            credit_d = sum[4:0];
            state_d  = COLLECT;
          end
        end
      end
      VEND: begin
        credit_d = 5'd0;
        state_d  = IDLE;
      end
      default: begin
        credit_d = 5'd0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      credit_q <= 5'd0;
      out_q    <= 1'b0;
      change_q <= 3'd0;
`ifdef VM_SELECT_LOCK_EN
      sel_q    <= 3'd0;
`endif
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      out_q    <= out_d;
      change_q <= change_d;
`ifdef VM_SELECT_LOCK_EN
      sel_q    <= sel_d;
`endif
    end
  end

  assign bus.out    = out_q;
  assign bus.change = change_q;

endmodule

// File: tb/tb_vending_machine.sv
// Scoreboard bench for vending_machine: a credit-arithmetic model predicts each vend edge and change.
// A negedge monitor checks every cycle against the queued expectations.
module tb_vending_machine;

  logic clk = 1'b0;
  logic rst;

  vending_machine_if vif ();

  vending_machine dut (
    .clk (clk),
    .rst (rst),
    .bus (vif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int edge_no;
    int change;
  } exp_t;

  exp_t sb[$];

  int edge_no  = 0;
  int n_checks = 0;
  int n_fail   = 0;

  int prices[8]     = '{5, 6, 8, 10, 12, 15, 3, 20};
  int coin_units[8] = '{0, 1, 2, 5, 0, 0, 0, 0};

  int credit     = 0;
  bit vend_prev  = 1'b0;
  int locked_sel = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edge_no, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then advance the reference model across the same edge.
  task automatic applyStimulus(input logic [2:0] coin, input logic [2:0] sel, input logic r);
    int v;
    int p;
    int sum;
    exp_t e;
    vif.in             = coin;
    vif.product_select = sel;
    rst                = r;
    @(posedge clk);
    edge_no++;
    if (r) begin
      credit    = 0;
      vend_prev = 1'b0;
    end else if (vend_prev) begin
      vend_prev = 1'b0;
    end else begin
      v = coin_units[coin];
      if (v > 0) begin
`ifdef VM_SELECT_LOCK_EN
        if (credit == 0) locked_sel = int'(sel);
        p = prices[locked_sel];
`else
        p = prices[sel];
`endif
        sum = credit + v;
        if (sum >= p) begin
          e.edge_no = edge_no;
          e.change  = (sum - p) % 8;
          sb.push_back(e);
          credit    = 0;
          vend_prev = 1'b1;
        end else begin
          credit = sum;
        end
      end
    end
    #2;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (edge_no > 0) begin
      if (vif.out === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_vend", int'(vif.out), 0);
        end else begin
          e = sb.pop_front();
          checkOutput("vend_edge", edge_no, e.edge_no);
          checkOutput("vend_change", int'(vif.change), e.change);
        end
      end else begin
        checkOutput("idle_change", int'(vif.change), 0);
        if (sb.size() > 0 && sb[0].edge_no <= edge_no) begin
          void'(sb.pop_front());
          checkOutput("missed_vend", int'(vif.out), 1);
        end
      end
    end
  end

  initial begin
    vif.in             = 3'b000;
    vif.product_select = 3'd0;
    rst                = 1'b1;

    applyStimulus(3'b000, 3'd0, 1'b1);
    applyStimulus(3'b011, 3'd0, 1'b1);
    checkOutput("reset_out", int'(vif.out), 0);
    checkOutput("reset_change", int'(vif.change), 0);

    for (int i = 0; i < 5; i++) applyStimulus(3'b010, 3'd0, 1'b0);
    applyStimulus(3'b000, 3'd0, 1'b0);
    applyStimulus(3'b000, 3'd0, 1'b1);

    applyStimulus(3'b011, 3'd6, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(3'b000, 3'd6, 1'b0);

    applyStimulus(3'b000, 3'd0, 1'b1);
    applyStimulus(3'b001, 3'd0, 1'b0);
    applyStimulus(3'b001, 3'd0, 1'b0);
    applyStimulus(3'b101, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(3'b001, 3'd0, 1'b0);
    applyStimulus(3'b000, 3'd0, 1'b0);

    applyStimulus(3'b000, 3'd7, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(3'b011, 3'd7, 1'b0);
    applyStimulus(3'b000, 3'd7, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(3'b011, 3'd7, 1'b0);
    applyStimulus(3'b011, 3'd7, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(3'b011, 3'd7, 1'b0);
    applyStimulus(3'b000, 3'd7, 1'b0);

    applyStimulus(3'b000, 3'd3, 1'b1);
    applyStimulus(3'b011, 3'd3, 1'b0);
    applyStimulus(3'b001, 3'd0, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(3'b000, 3'd0, 1'b0);

    begin
      logic [2:0] sel;
      sel = 3'd0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 7) == 0) sel = 3'($urandom_range(0, 7));
        applyStimulus(3'($urandom_range(0, 7)), sel, ($urandom_range(0, 49) == 0));
      end
    end

    for (int i = 0; i < 3; i++) applyStimulus(3'b000, 3'd0, 1'b0);
    checkOutput("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
